// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared types and line/beat geometry for the L1-to-memory arbiter
package cache_mem_arbiter_pkg;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    typedef enum logic {ld = 1'b0, st = 1'b1} mem_op_t;
    typedef enum logic [1:0] {arb_idle, arb_burst, arb_done} arb_state_t;
    typedef enum logic {req_i = 1'b0, req_d = 1'b1} arb_req_t;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: icache/dcache request ports and the physical-memory burst port
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = cache_mem_arbiter_pkg::LINE_W,
    parameter int BEAT_W = cache_mem_arbiter_pkg::BEAT_W
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter_burst_line_buffer.sv
// cache_mem_arbiter_burst_line_buffer: line register with full-line load and beat-indexed write/read
module cache_mem_arbiter_burst_line_buffer #(
    parameter int LINE_W = cache_mem_arbiter_pkg::LINE_W,
    parameter int BEAT_W = cache_mem_arbiter_pkg::BEAT_W,
    parameter int IDX_W  = (LINE_W / BEAT_W > 1) ? $clog2(LINE_W / BEAT_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  beat,
    input  logic [BEAT_W-1:0] wr_data,
    output logic [BEAT_W-1:0] rd_data,
    output logic [LINE_W-1:0] line
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) line <= '0;
        else if (fill) line <= fill_line;
        else if (wr_en) line[BEAT_W * beat +: BEAT_W] <= wr_data;
    end

    assign rd_data = line[BEAT_W * beat +: BEAT_W];
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: alternating-fair arbiter turning icache/dcache line requests into 4-beat memory bursts
module cache_mem_arbiter #(
    parameter int LINE_W = cache_mem_arbiter_pkg::LINE_W,
    parameter int BEAT_W = cache_mem_arbiter_pkg::BEAT_W,
    parameter int ADDR_W = 32
) (
    input logic clk,
    input logic rst_n,
    cache_mem_arbiter_if.slave bus
);
    import cache_mem_arbiter_pkg::*;

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(LINE_W / 8 - 1);

    arb_state_t        state, state_nx;
    arb_req_t          req, last_grant, pick;
    mem_op_t           op;
    logic [IDX_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line, i_hold, d_hold;
    logic [BEAT_W-1:0] beat_rd;
    logic              i_pend, d_pend, grant, fill, last_beat, capture, in_burst, in_done;

    always_comb begin
        i_pend    = bus.i_read;
        d_pend    = bus.d_read | bus.d_write;
        in_burst  = state == arb_burst;
        in_done   = state == arb_done;
        grant     = state == arb_idle && (i_pend || d_pend);
        pick      = d_pend && (!i_pend || last_grant == req_i) ? req_d : req_i;
        fill      = grant && pick == req_d && bus.d_write;
        capture   = in_burst && bus.pmem_resp && op == ld;
        last_beat = in_burst && bus.pmem_resp && cnt == IDX_W'(BEATS - 1);
        state_nx  = grant ? arb_burst : last_beat ? arb_done : in_done ? arb_idle : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= arb_idle;
            cnt        <= '0;
            last_grant <= req_i;
            req        <= req_i;
            op         <= ld;
            addr       <= '0;
            i_hold     <= '0;
            d_hold     <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                req        <= pick;
                last_grant <= pick;
                op         <= (pick == req_d && bus.d_write) ? st : ld;
                addr       <= (pick == req_d ? bus.d_addr : bus.i_addr) & ALIGN;
            end
            if (in_burst && bus.pmem_resp) cnt <= cnt + 1'b1;
            if (in_done && op == ld && req == req_i) i_hold <= line;
            if (in_done && op == ld && req == req_d) d_hold <= line;
        end
    end

    cache_mem_arbiter_burst_line_buffer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .IDX_W(IDX_W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill      (fill),
        .fill_line (bus.d_wdata),
        .wr_en     (capture),
        .beat      (cnt),
        .wr_data   (bus.pmem_rdata),
        .rd_data   (beat_rd),
        .line      (line)
    );

    // Everything on the memory side is decoded from latched state, never from request inputs
    assign bus.pmem_read  = in_burst && op == ld;
    assign bus.pmem_write = in_burst && op == st;
    assign bus.pmem_addr  = in_burst ? addr : '0;
    assign bus.pmem_wdata = (in_burst && op == st) ? beat_rd : '0;
    assign bus.i_resp     = in_done && req == req_i;
    assign bus.d_resp     = in_done && req == req_d;
    assign bus.i_rdata    = (in_done && req == req_i && op == ld) ? line : i_hold;
    assign bus.d_rdata    = (in_done && req == req_d && op == ld) ? line : d_hold;

    assert property (@(posedge clk) disable iff (!rst_n) !(bus.d_read && bus.d_write))
        else $warning("d_read and d_write high together; serviced as a writeback");
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench with a beat-level memory model and per-requester agents
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    typedef struct {
        logic         d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } item_t;

    logic clk = 0;
    logic rst_n = 1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if bus ();
    cache_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    item_t bq[$];
    item_t rq[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    gap = 0, beat_k = 0, wait_k = 0, rd_cyc = 0, wr_cyc = 0;
    logic  spur = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [31:0] a, input int k);
        logic [7:0] b;
        b = 8'((k + 1) * 17) ^ a[31:24];
        return {8{b}};
    endfunction

    function automatic logic [255:0] rline(input logic [31:0] a);
        return {pat(a, 3), pat(a, 2), pat(a, 1), pat(a, 0)};
    endfunction

    function automatic logic [255:0] wline(input logic [7:0] s);
        return {{8{s + 8'd3}}, {8{s + 8'd2}}, {8{s + 8'd1}}, {8{s}}};
    endfunction

    task automatic expect_burst(input logic d, input logic wr, input logic [31:0] a, input logic [255:0] w);
        item_t e;
        e.d = d;
        e.wr = wr;
        e.addr = a;
        e.line = wr ? w : rline(a);
        bq.push_back(e);
    endtask

    task automatic serve(input logic d, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [255:0] w, output int lat);
        if (d) begin
            bus.d_read = rd; bus.d_write = wr; bus.d_addr = a; bus.d_wdata = w;
        end else begin
            bus.i_read = 1; bus.i_addr = a;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(d ? bus.d_resp : bus.i_resp) && lat < 400);
        chk(d ? "d_served" : "i_served", d ? bus.d_resp : bus.i_resp, 1'b1);
        if (d) begin
            bus.d_read = 0; bus.d_write = 0;
        end else bus.i_read = 0;
        @(negedge clk);
    endtask

    // Memory model: answers each beat after `gap` idle cycles and checks the burst against bq
    initial begin
        item_t e;
        bus.pmem_resp = 0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 0;
            if (!rst_n) begin
                beat_k = 0; wait_k = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (bus.pmem_read) rd_cyc++;
                if (bus.pmem_write) wr_cyc++;
                chk("burst_expected", bq.size() != 0, 1'b1);
                if (bq.size() != 0) begin
                    e = bq[0];
                    chk("pmem_addr", bus.pmem_addr, e.addr);
                    chk("pmem_op", {bus.pmem_write, bus.pmem_read}, e.wr ? 2'b10 : 2'b01);
                    if (e.wr) chk("pmem_wdata", bus.pmem_wdata, e.line[64 * beat_k +: 64]);
                    if (wait_k < gap) wait_k++;
                    else begin
                        wait_k = 0;
                        bus.pmem_resp = 1;
                        bus.pmem_rdata = pat(bus.pmem_addr, beat_k);
                        beat_k++;
                        if (beat_k == 4) begin
                            beat_k = 0;
                            rq.push_back(bq.pop_front());
                        end
                    end
                end
            end else begin
                beat_k = 0; wait_k = 0;
                bus.pmem_resp = spur;
            end
        end
    end

    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (bus.i_resp || bus.d_resp) begin
                chk("resp_expected", rq.size() != 0, 1'b1);
                if (rq.size() != 0) begin
                    e = rq.pop_front();
                    chk("resp_who", {bus.d_resp, bus.i_resp}, e.d ? 2'b10 : 2'b01);
                    chk("done_pmem_idle", {bus.pmem_read, bus.pmem_write}, 2'b00);
                    if (!e.wr) chk(e.d ? "d_rdata" : "i_rdata", e.d ? bus.d_rdata : bus.i_rdata, e.line);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat2, n;
        bus.i_read = 0; bus.i_addr = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
        #1 rst_n = 0;
        #1;
        chk("rst_pmem_read", bus.pmem_read, 1'b0);
        chk("rst_pmem_write", bus.pmem_write, 1'b0);
        chk("rst_pmem_addr", bus.pmem_addr, 32'h0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 64'h0);
        chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("rst_i_rdata", bus.i_rdata, 256'h0);
        chk("rst_d_rdata", bus.d_rdata, 256'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Both requesters held from reset: first tie goes to D, then grants alternate
        expect_burst(1, 0, 32'h0100_0000, '0);
        expect_burst(0, 0, 32'h0200_0000, '0);
        expect_burst(1, 0, 32'h0500_0000, '0);
        expect_burst(0, 0, 32'h0600_0000, '0);
        fork
            begin
                serve(1, 1, 0, 32'h0100_0000, '0, lat);
                serve(1, 1, 0, 32'h0500_0000, '0, lat);
            end
            begin
                serve(0, 1, 0, 32'h0200_0000, '0, lat2);
                serve(0, 1, 0, 32'h0600_0000, '0, lat2);
            end
        join

        rd_cyc = 0;
        expect_burst(0, 0, 32'h0000_1220, '0);
        serve(0, 1, 0, 32'h0000_1234, '0, lat);
        chk("i_latency", lat, 5);
        chk("rd_cycles", rd_cyc, 4);

        gap = 2;
        wr_cyc = 0;
        expect_burst(1, 1, 32'h8000_0040, wline(8'h01));
        serve(1, 0, 1, 32'h8000_0040, wline(8'h01), lat);
        chk("wr_cycles", wr_cyc, 12);
        chk("wr_latency", lat, 13);
        gap = 0;

        spur = 1;
        repeat (3) begin
            @(negedge clk);
            #1 chk("spur_idle", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 4'b0);
        end
        spur = 0;

        expect_burst(0, 0, 32'h0300_0040, '0);
        fork
            serve(0, 1, 0, 32'h0300_005C, '0, lat);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    #1 n++;
                end while (!bus.pmem_read && n < 20);
                bus.i_addr = 32'hDEAD_BEEF;
            end
        join

        // Reset in the middle of a read burst; the held request must restart from beat 0
        expect_burst(0, 0, 32'h0400_0020, '0);
        fork
            serve(0, 1, 0, 32'h0400_0027, '0, lat);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    #1 n++;
                end while (beat_k != 2 && n < 50);
                chk("beat2_reached", beat_k, 2);
                #1 rst_n = 0;
                #1;
                chk("abort_read", bus.pmem_read, 1'b0);
                chk("abort_addr", bus.pmem_addr, 32'h0);
                chk("abort_i_rdata", bus.i_rdata, 256'h0);
                repeat (2) begin
                    @(negedge clk);
                    #1 chk("abort_noresp", {bus.i_resp, bus.d_resp}, 2'b00);
                end
                rst_n = 1;
            end
        join

        expect_burst(1, 1, 32'h8000_0080, wline(8'h50));
        serve(1, 1, 1, 32'h8000_0095, wline(8'h50), lat);

        repeat (3) @(negedge clk);
        chk("bursts_drained", bq.size(), 0);
        chk("resps_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory burst port between the instruction cache (read-only) and the data cache (read/write) of the OOPs core.
- Accepts whole-line requests (256 b) and sequences each one as a 4-beat, 64-bit burst on the memory side.
- Grants one requester at a time with alternating fairness, then returns a one-cycle response to the requester it served.
- Sits between the two L1 caches and the memory model / cacheline adaptor.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory bus width in bits; BEATS = LINE_W/BEAT_W (4) is a derived localparam and must be a power of two.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  icache line read request; level, held until i_resp.
- i_addr  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  line returned to icache; valid while i_resp=1.
- i_resp  out  1  one-cycle completion pulse to icache.
- d_read  in  1  dcache line read request; level, held until d_resp.
- d_write  in  1  dcache line writeback request; level, held until d_resp.
- d_addr  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  writeback line; stable while d_write=1.
- d_rdata  out  LINE_W  line returned to dcache; valid while d_resp=1.
- d_resp  out  1  one-cycle completion pulse to dcache.
- pmem_read  out  1  memory burst read, held for the whole burst.
- pmem_write  out  1  memory burst write, held for the whole burst.
- pmem_addr  out  ADDR_W  burst base address; low log2(LINE_W/8) bits forced to 0.
- pmem_wdata  out  BEAT_W  current write beat.
- pmem_rdata  in  BEAT_W  current read beat; valid when pmem_resp=1.
- pmem_resp  in  1  per-beat acknowledge.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, beat counter=0, last_grant=ICACHE. All outputs are 0, including both rdata buses, pmem_addr and pmem_wdata.
- Reset asserted mid-burst aborts immediately: pmem_read/pmem_write drop in the same cycle and no resp is issued.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - Only i pending -> grant I.
  - Only d pending -> grant D.
  - Both pending -> grant the requester that is not last_grant, so the first tie after reset goes to D.
  - On grant: latch requester, op (mem_op_t: st if d_write, else ld), aligned address and write line; update last_grant; go to BURST.
  - d_read and d_write both high is illegal (simulation assertion fires); RTL treats it as st.
- BURST:
  - pmem_read = (op==ld), pmem_write = (op==st), pmem_addr = latched address.
  - pmem_wdata = latched line[BEAT_W*cnt +: BEAT_W].
  - On pmem_resp: for ld, capture pmem_rdata into buffer slot cnt; then cnt++.
  - On the beat where cnt==BEATS-1 and pmem_resp=1: cnt wraps to 0, go to DONE.
  - Requests arriving during BURST are not sampled. Requester inputs changing during BURST do not affect the burst, because everything is latched.
- DONE:
  - pmem_read/pmem_write are 0.
  - Exactly one of i_resp/d_resp is 1 for one cycle; the matching rdata = buffer (valid for ld, undefined content for st).
  - Go to IDLE unconditionally.
- i_rdata/d_rdata hold their last value until that requester's next read completes.
- pmem_resp while in IDLE or DONE is ignored.
- Minimum latency: request sampled at edge t -> pmem_read high in cycle t+1 -> with pmem_resp every cycle, beats land t+1..t+4 -> resp in cycle t+5.
- Requester deasserts after seeing resp. A request still high in the IDLE cycle after DONE is treated as a new request; caches must not leave one up.
- No combinational path from request inputs to pmem outputs; all pmem outputs are registered or decoded from state.

Decomposition:
- Add to rv32i_types:
  - arb_state_t enum {arb_idle, arb_burst, arb_done}.
  - arb_req_t enum {req_i=1'b0, req_d=1'b1}.
  - Constants LINE_W=256, BEAT_W=64.
  - Reuse mem_op_t for the latched op.
- One sub-module, burst_line_buffer: LINE_W register with beat-indexed write, full-line load, and beat-indexed read mux. FSM and grant logic stay in the top module.

Test Plan:
- i_read only, i_addr=0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> pmem_addr=0x0000_1220 and pmem_read high for 4 cycles; i_resp one cycle at t+5; i_rdata={0x44..,0x33..,0x22..,0x11..}; d_resp stays 0.
- d_write with d_addr=0x8000_0040, d_wdata beat k = k+1 replicated, pmem_resp with 2 idle cycles between beats -> pmem_wdata steps 1,2,3,4 only after each resp; pmem_write stays high throughout; d_resp one cycle after beat 4.
- i_read and d_read both high from reset -> D served first, then I, then I again only if D is absent; with both held repeatedly, grants alternate D,I,D,I.
- rst_n pulled low during beat 2 of a read -> pmem_read=0 immediately; no resp; after release, state=IDLE and a held request restarts with beat 0 at the same address.
- Spurious pmem_resp in IDLE, and i_addr changing during BURST -> no state change and no effect; pmem_addr stays at the latched value.
- d_read and d_write both high -> assertion fires and a write burst is performed.
